// File: rtl/color_pkg.sv
// ---------------------------------------------------------------------------
// color_pkg
// Shared types and constants for the colour-round controller:
//   - colour width, platform count and the reserved BLACK colour
//   - FSM state enumeration
//   - Galois LFSR tap constant and step function
//   - helpers for the platform fallback colour and final platform placement
// ---------------------------------------------------------------------------
package color_pkg;

  localparam int COLOR_W     = 3;
  localparam int NUM_PLATS   = 4;
  localparam int DRAWN_PLATS = NUM_PLATS - 1;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK         = 3'b000;
  localparam color_t BALL_FALLBACK = 3'b001;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAW_BALL = 3'd1,
    ST_DRAW_PLAT = 3'd2,
    ST_PLACE     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // One Galois LFSR step: shift right, fold taps in when the bit leaving is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Forced non-matching colour: ball+1 mod 8, stepping over BLACK.
  function automatic color_t plat_fallback(input color_t ball);
    color_t res;
    if (ball == 3'b111) begin
      res = 3'b001;
    end else begin
      res = ball + 3'd1;
    end
    return res;
  endfunction

  // Ball goes to slot pos; the drawn colours fill the other slots in
  // ascending index order. Platform n occupies bits [3n+2:3n].
  function automatic logic [NUM_PLATS*COLOR_W-1:0] place_colors(
    input color_t                        ball,
    input color_t [DRAWN_PLATS-1:0]      drawn,
    input logic   [1:0]                  pos
  );
    logic [NUM_PLATS*COLOR_W-1:0] res;
    case (pos)
      2'd0:    res = {drawn[2], drawn[1], drawn[0], ball};
      2'd1:    res = {drawn[2], drawn[1], ball, drawn[0]};
      2'd2:    res = {drawn[2], ball, drawn[1], drawn[0]};
      2'd3:    res = {ball, drawn[2], drawn[1], drawn[0]};
      default: res = {drawn[2], drawn[1], drawn[0], ball};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/color_round_ctrl_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR that steps every cycle unless a load is requested.
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   synchronous active-low reset, loads SEED
//   load      in   load load_val instead of stepping this cycle
//   load_val  in   16-bit value to load
//   q         out  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import color_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next state: load takes priority over the free-running step.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else begin
      q_d = lfsr_step(q_q);
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/color_round_ctrl.sv
// ---------------------------------------------------------------------------
// color_round_ctrl
// Draws a ball colour and three non-matching platform colours from an LFSR,
// places the ball colour on one of four platforms and presents the set with
// a one-cycle done pulse.
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   start        in   request a round (sampled in IDLE only)
//   seed_load    in   load seed into the LFSR (IDLE only; 0 maps to SEED)
//   seed         in   16-bit seed value
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when the colour set is valid
//   ball_color   out  3-bit ball colour
//   plat_colors  out  4 x 3-bit platform colours, platform n at [3n+2:3n]
//   match_pos    out  platform index holding the ball colour
// ---------------------------------------------------------------------------
module color_round_ctrl
  import color_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [3:0]  MAX_TRIES = 4'd8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           seed_load,
  input  logic [15:0]                    seed,
  output logic                           busy,
  output logic                           done,
  output logic [COLOR_W-1:0]             ball_color,
  output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors,
  output logic [1:0]                     match_pos
);

  state_e                        state_q, state_d;
  logic [3:0]                    try_q, try_d;
  logic [1:0]                    slot_q, slot_d;
  color_t                        ball_q, ball_d;
  color_t [DRAWN_PLATS-1:0]      drawn_q, drawn_d;
  color_t                        ball_color_q, ball_color_d;
  logic [NUM_PLATS*COLOR_W-1:0]  plat_colors_q, plat_colors_d;
  logic [1:0]                    match_pos_q, match_pos_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [15:0] lfsr_s;
  logic        lfsr_load_s;
  logic [15:0] lfsr_load_val_s;
  logic        lfsr_zero_s;
  color_t      cand_s;
  logic        fallback_s;
  color_t      plat_pick_s;
  logic        plat_ok_s;

  assign cand_s      = lfsr_s[2:0];
  assign fallback_s  = (try_q == (MAX_TRIES - 4'd1));
  assign lfsr_zero_s = (lfsr_s == 16'h0000);

  // LFSR load control: seed loads in IDLE (zero seed replaced by SEED);
  // an all-zero state is unreachable but is recovered from if an upset
  // ever produces it.
  always_comb begin
    lfsr_load_s     = 1'b0;
    lfsr_load_val_s = SEED;
    if (lfsr_zero_s) begin
      lfsr_load_s     = 1'b1;
      lfsr_load_val_s = SEED;
    end else if ((state_q == ST_IDLE) && seed_load) begin
      lfsr_load_s     = 1'b1;
      lfsr_load_val_s = (seed == 16'h0000) ? SEED : seed;
    end else begin
      lfsr_load_s     = 1'b0;
      lfsr_load_val_s = SEED;
    end
  end

  lfsr16 #(
    .SEED     (SEED)
  ) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (lfsr_load_s),
    .load_val (lfsr_load_val_s),
    .q        (lfsr_s)
  );

  // Platform draw decision for the current cycle.
  always_comb begin
    plat_pick_s = cand_s;
    plat_ok_s   = 1'b0;
    if (fallback_s) begin
      plat_pick_s = plat_fallback(ball_q);
      plat_ok_s   = 1'b1;
    end else if ((cand_s != BLACK) && (cand_s != ball_q)) begin
      plat_pick_s = cand_s;
      plat_ok_s   = 1'b1;
    end else begin
      plat_pick_s = cand_s;
      plat_ok_s   = 1'b0;
    end
  end

  // FSM next state, try/slot counters, working colours and output registers.
  always_comb begin
    state_d       = state_q;
    try_d         = try_q;
    slot_d        = slot_q;
    ball_d        = ball_q;
    drawn_d       = drawn_q;
    ball_color_d  = ball_color_q;
    plat_colors_d = plat_colors_q;
    match_pos_d   = match_pos_q;

    case (state_q)
      ST_IDLE: begin
        try_d  = 4'd0;
        slot_d = 2'd0;
        if (start) begin
          state_d = ST_DRAW_BALL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAW_BALL: begin
        if (fallback_s) begin
          ball_d  = BALL_FALLBACK;
          try_d   = 4'd0;
          state_d = ST_DRAW_PLAT;
        end else if (cand_s != BLACK) begin
          ball_d  = cand_s;
          try_d   = 4'd0;
          state_d = ST_DRAW_PLAT;
        end else begin
          try_d   = try_q + 4'd1;
        end
      end

      ST_DRAW_PLAT: begin
        if (plat_ok_s) begin
          try_d = 4'd0;
          case (slot_q)
            2'd0:    drawn_d[0] = plat_pick_s;
            2'd1:    drawn_d[1] = plat_pick_s;
            2'd2:    drawn_d[2] = plat_pick_s;
            default: drawn_d    = drawn_q;
          endcase
          if (slot_q == 2'd2) begin
            slot_d  = 2'd0;
            state_d = ST_PLACE;
          end else begin
            slot_d  = slot_q + 2'd1;
          end
        end else begin
          try_d = try_q + 4'd1;
        end
      end

      ST_PLACE: begin
        ball_color_d  = ball_q;
        match_pos_d   = lfsr_s[1:0];
        plat_colors_d = place_colors(ball_q, drawn_q, lfsr_s[1:0]);
        state_d       = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        try_d   = 4'd0;
        slot_d  = 2'd0;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      try_q         <= 4'd0;
      slot_q        <= 2'd0;
      ball_q        <= BLACK;
      drawn_q       <= '0;
      ball_color_q  <= BLACK;
      plat_colors_q <= '0;
      match_pos_q   <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      try_q         <= try_d;
      slot_q        <= slot_d;
      ball_q        <= ball_d;
      drawn_q       <= drawn_d;
      ball_color_q  <= ball_color_d;
      plat_colors_q <= plat_colors_d;
      match_pos_q   <= match_pos_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ball_color  = ball_color_q;
  assign plat_colors = plat_colors_q;
  assign match_pos   = match_pos_q;

endmodule

// File: tb/tb_color_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_color_round_ctrl
// Scoreboard bench: each test pushes the expected round outcome into a
// queue; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_color_round_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        seed_load;
  logic [15:0] seed;
  logic        busy;
  logic        done;
  logic [2:0]  ball_color;
  logic [11:0] plat_colors;
  logic [1:0]  match_pos;

  always #5 clk = ~clk;

  color_round_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .seed_load   (seed_load),
    .seed        (seed),
    .busy        (busy),
    .done        (done),
    .ball_color  (ball_color),
    .plat_colors (plat_colors),
    .match_pos   (match_pos)
  );

  typedef struct {
    bit          exact;
    logic [2:0]  ball;
    logic [11:0] plats;
    logic [1:0]  pos;
    int          lat_min;
    int          lat_max;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       errors = 0;
  int       busy_cycles = 0;
  bit [3:0] seen_pos = 4'b0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_inv();
    exp_t e;
    e.exact = 1'b0; e.ball = 3'b000; e.plats = 12'h000; e.pos = 2'd0;
    e.lat_min = 5; e.lat_max = 33;
    sb.push_back(e);
  endtask

  task automatic push_exact(input logic [2:0] b, input logic [11:0] p,
                            input logic [1:0] m, input int lat);
    exp_t e;
    e.exact = 1'b1; e.ball = b; e.plats = p; e.pos = m;
    e.lat_min = lat; e.lat_max = lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, sb.size());
      sb.delete();
    end
    tick();
  endtask

  // Monitor: measure latency in busy cycles and score every done pulse.
  initial begin : monitor
    exp_t       e;
    int         nm;
    int         nz;
    int         lat;
    logic [2:0] p;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        busy_cycles = 0;
      end else if (done === 1'b1) begin
        lat = busy_cycles;
        busy_cycles = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
        end else begin
          e  = sb.pop_front();
          nm = 0;
          nz = 0;
          for (int n = 0; n < 4; n++) begin
            p = plat_colors[3*n +: 3];
            if (p == ball_color) nm++;
            if (p == 3'b000) nz++;
          end
          if (ball_color == 3'b000) nz++;
          check("one_match", nm, 32'd1);
          check("no_black", nz, 32'd0);
          check("match_at_pos", 32'(plat_colors[3*match_pos +: 3]), 32'(ball_color));
          checks++;
          if (lat < e.lat_min || lat > e.lat_max) begin
            errors++;
            $display("FAIL latency actual=%0d required=%0d..%0d", lat, e.lat_min, e.lat_max);
          end
          if (e.exact) begin
            check("ball_color", 32'(ball_color), 32'(e.ball));
            check("plat_colors", 32'(plat_colors), 32'(e.plats));
            check("match_pos", 32'(match_pos), 32'(e.pos));
          end
          seen_pos[match_pos] = 1'b1;
        end
      end else if (busy === 1'b1) begin
        busy_cycles++;
      end
    end
  end

  // Stimulus.
  initial begin : stim
    resetn = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 16'h0000;
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ball", 32'(ball_color), 32'd0);
    check("rst_plats", 32'(plat_colors), 32'd0);
    check("rst_pos", 32'(match_pos), 32'd0);

    // Seed 16'h1234, then a start pulse: invariants and 5..33 latency.
    seed = 16'h1234; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    push_inv();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain("seed1234", 60);

    // Zero seed with simultaneous start: LFSR holds ACE1, round fully known.
    // ACE1 -> ball 001; E270,7138 rejected; 389C,1C4E,0E27 -> 100,110,111;
    // PLACE sees B313 -> pos 3.
    push_exact(3'b001, 12'h3F4, 2'd3, 7);
    seed = 16'h0000; seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("zero_seed_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
    wait_drain("zero_seed", 60);

    // Seed 8000 keeps lfsr[2:0]=000 for 13 cycles: ball falls back to 001,
    // platforms 100 and 010 drawn, third platform falls back to 010,
    // PLACE sees 0168 -> pos 0. Mid-round start/seed_load are ignored.
    push_exact(3'b001, 12'h4A1, 2'd0, 24);
    seed = 16'h8000; seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    repeat (3) tick();
    seed = 16'h0000; seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    wait_drain("fallback", 60);

    // Abort: reset sampled at the end of the third round cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ball", 32'(ball_color), 32'd0);
    check("abort_plats", 32'(plat_colors), 32'd0);
    check("abort_pos", 32'(match_pos), 32'd0);
    repeat (40) tick();
    push_inv();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain("after_abort", 60);

    // Soak: 1000 back-to-back rounds with start held high.
    for (int r = 0; r < 1000; r++) push_inv();
    start = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      tick();
      if (start && busy && !done && (sb.size() == 1)) start = 1'b0;
      if (sb.size() == 0) break;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL soak_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    repeat (40) tick();
    for (int i = 0; i < 4; i++) check("pos_seen", 32'(seen_pos[i]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_round_ctrl.md
COLOR_ROUND_CTRL -- requirements
Module: color_round_ctrl

Interface
REQ-001 Parameter SEED, default 16'hACE1, is the LFSR value loaded at reset.
REQ-002 Parameter MAX_TRIES, default 4'd8, is the number of draw attempts per colour slot, including the final fallback attempt.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new colour round; sampled only in IDLE.
REQ-006 seed_load  input  1  load seed into the LFSR; honoured only in IDLE.
REQ-007 seed  input  16  seed value for seed_load.
REQ-008 busy  output  1  high while a round is in progress (any state except IDLE).
REQ-009 done  output  1  one-cycle pulse: the new colour set is valid.
REQ-010 ball_color  output  3  colour of the ball for this round.
REQ-011 plat_colors  output  12  four 3-bit platform colours; platform n occupies [3n+2:3n].
REQ-012 match_pos  output  2  index of the platform whose colour equals ball_color.

Function
REQ-013 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle, except the cycle in which it loads.
REQ-014 seed_load in IDLE SHALL load seed; seed==0 SHALL load SEED instead, so the LFSR never locks at zero.
REQ-015 If seed_load and start are both high in IDLE, the load SHALL take effect and start SHALL also be accepted.
REQ-016 FSM states SHALL be IDLE, DRAW_BALL, DRAW_PLAT, PLACE and DONE.
REQ-017 Transitions: IDLE->DRAW_BALL on start; DRAW_BALL->DRAW_PLAT on accept; DRAW_PLAT->PLACE after 3 accepts; PLACE->DONE; DONE->IDLE.
REQ-018 Each draw cycle SHALL take candidate = lfsr[2:0].
REQ-019 Ball acceptance rule: candidate != 3'b000 (black).
REQ-020 Non-matching platform acceptance rule: candidate != 3'b000, candidate != ball colour.
REQ-021 A rejected draw SHALL retry on the next cycle.
REQ-022 Fallback: on attempt MAX_TRIES of a slot the controller SHALL force the value instead of drawing.
REQ-023 Ball fallback value SHALL be 3'b001.
REQ-024 Platform fallback value SHALL be ball+1 modulo 8, skipping 000; for ball 3'b111 it SHALL be 3'b001.
REQ-025 The try counter SHALL clear on every accept and on entry to each slot.
REQ-026 PLACE SHALL set match_pos = lfsr[1:0].
REQ-027 The three drawn platform colours SHALL fill the remaining indices in ascending order.
REQ-028 ball_color, plat_colors and match_pos SHALL update only on the PLACE->DONE edge and hold until the next such edge.
REQ-029 done SHALL be high exactly during DONE.
REQ-030 Latency from the start-sampling edge to done high SHALL be 5 cycles minimum and 1+3+1 + retries cycles in general, with a maximum of 33 cycles when MAX_TRIES=8.
REQ-031 start while busy, and a held start on the cycle done is high, SHALL be ignored.
REQ-032 start held high in IDLE after DONE SHALL begin a new round.
REQ-033 Invariants at done: exactly one platform equals ball_color; no colour is 000.

Reset
REQ-034 resetn low at a clock edge SHALL set state=IDLE, lfsr=SEED, try counter=0, busy=0, done=0, ball_color=0, plat_colors=0, match_pos=0.
REQ-035 Reset asserted mid-round SHALL abort the round with no done pulse; outputs SHALL return to zero.

Structure
REQ-036 Package color_pkg SHALL hold COLOR_W=3, NUM_PLATS=4, BLACK=3'b000, the state enumeration and the LFSR tap constant.
REQ-037 The LFSR SHALL be a sub-module named lfsr16, with ports clk, resetn, load, load_val and q.
REQ-038 The FSM, try counter, slot counter and output registers SHALL reside in color_round_ctrl.

Verification
REQ-039 Reset: hold resetn=0 for 2 cycles, then release -> busy=0, done=0, all colour outputs 0.
REQ-040 Latency: seed_load with 16'h1234, then start pulse -> done exactly once, within 5..33 cycles; REQ-033 invariants hold.
REQ-041 Zero seed: seed_load with seed=0 -> the LFSR holds 16'hACE1 on the next cycle.
REQ-042 Fallback: force lfsr[2:0]=000 for 10 cycles -> ball_color=3'b001 and done at or before cycle 33.
REQ-043 Abort: resetn=0 in the third cycle of a round -> no done pulse; all outputs 0; a subsequent start completes normally.
REQ-044 Soak: 1000 back-to-back rounds with start held high -> REQ-033 holds every round; each match_pos value 0..3 occurs at least once.
